// File: rtl/emit_unique_bit_sequence_if.sv
// Frame-emitter bus: frame request, payload byte handshake and serial bit output.
interface emit_unique_bit_sequence_if #(
    parameter int unsigned LEN_PREAMBLE            = 8,
    parameter int unsigned LEN_UNIQUE_BIT_SEQUENCE = 32
);
    logic                               start;
    logic [LEN_PREAMBLE-1:0]            preamble;
    logic [LEN_UNIQUE_BIT_SEQUENCE-1:0] unique_bit_sequence;
    logic [7:0]                         num_payload_byte;
    logic                               bit_strobe;
    logic [7:0]                         payload_byte;
    logic                               payload_byte_valid;
    logic                               payload_byte_ready;
    logic                               phy_bit;
    logic                               bit_valid;
    logic                               busy;
    logic                               done;
    logic                               underrun;

    // Frame source / payload producer side
    modport master (
        output start, preamble, unique_bit_sequence, num_payload_byte,
        output bit_strobe, payload_byte, payload_byte_valid,
        input  payload_byte_ready, phy_bit, bit_valid, busy, done, underrun
    );

    // Emitter side
    modport slave (
        input  start, preamble, unique_bit_sequence, num_payload_byte,
        input  bit_strobe, payload_byte, payload_byte_valid,
        output payload_byte_ready, phy_bit, bit_valid, busy, done, underrun
    );
endinterface

// File: rtl/emit_unique_bit_sequence.sv
// Serialises preamble, access address and payload bytes LSB first, one bit per strobe.
module emit_unique_bit_sequence #(
    parameter int unsigned LEN_PREAMBLE            = 8,
    parameter int unsigned LEN_UNIQUE_BIT_SEQUENCE = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    emit_unique_bit_sequence_if.slave       bus
);
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned MAX_HDR   = (LEN_PREAMBLE > LEN_UNIQUE_BIT_SEQUENCE) ?
                                        LEN_PREAMBLE : LEN_UNIQUE_BIT_SEQUENCE;
    localparam int unsigned MAX_FIELD = (MAX_HDR > BYTE_W) ? MAX_HDR : BYTE_W;
    localparam int unsigned CNT_W     = $clog2(MAX_FIELD + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        ACCESS   = 2'd2,
        PAYLOAD  = 2'd3
    } state_t;

    state_t                             state_q, state_d;
    logic [LEN_PREAMBLE-1:0]            pre_q, pre_d;
    logic [LEN_UNIQUE_BIT_SEQUENCE-1:0] ubs_q, ubs_d;
    logic [BYTE_W-1:0]                  num_q, num_d;
    logic [CNT_W-1:0]                   cnt_q, cnt_d;
    logic [BYTE_W-1:0]                  fetched_q, fetched_d;
    logic [BYTE_W-1:0]                  loaded_q, loaded_d;
    logic [BYTE_W-1:0]                  hold_q, hold_d;
    logic                               hold_full_q, hold_full_d;
    logic [BYTE_W-1:0]                  shift_q, shift_d;
    logic                               frame_end_q, frame_end_d;
    logic                               phy_bit_q, phy_bit_d;
    logic                               bit_valid_q, bit_valid_d;
    logic                               busy_q, busy_d;
    logic                               done_q, done_d;
    logic                               underrun_q, underrun_d;
    logic                               ready_q, ready_d;
    logic                               xfer;

    // Payload handshake uses the registered ready that the producer sees
    assign xfer = bus.payload_byte_valid & ready_q;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pre_q       <= '0;
            ubs_q       <= '0;
            num_q       <= '0;
            cnt_q       <= '0;
            fetched_q   <= '0;
            loaded_q    <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            frame_end_q <= 1'b0;
            phy_bit_q   <= 1'b0;
            bit_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            underrun_q  <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pre_q       <= pre_d;
            ubs_q       <= ubs_d;
            num_q       <= num_d;
            cnt_q       <= cnt_d;
            fetched_q   <= fetched_d;
            loaded_q    <= loaded_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            frame_end_q <= frame_end_d;
            phy_bit_q   <= phy_bit_d;
            bit_valid_q <= bit_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            underrun_q  <= underrun_d;
            ready_q     <= ready_d;
        end
    end

    // Next-state, bit emission and payload buffering
    always_comb begin
        state_d     = state_q;
        pre_d       = pre_q;
        ubs_d       = ubs_q;
        num_d       = num_q;
        cnt_d       = cnt_q;
        fetched_d   = fetched_q;
        loaded_d    = loaded_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        frame_end_d = 1'b0;
        phy_bit_d   = phy_bit_q;
        bit_valid_d = 1'b0;
        done_d      = 1'b0;
        underrun_d  = 1'b0;

        if (xfer) begin
            hold_d      = bus.payload_byte;
            hold_full_d = 1'b1;
            fetched_d   = fetched_q + 8'd1;
        end

        if (frame_end_q) begin
            // done/underrun cycle is still busy; return to IDLE one cycle later
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        pre_d       = bus.preamble;
                        ubs_d       = bus.unique_bit_sequence;
                        num_d       = bus.num_payload_byte;
                        cnt_d       = '0;
                        fetched_d   = '0;
                        loaded_d    = '0;
                        hold_full_d = 1'b0;
                        state_d     = PREAMBLE;
                    end
                end
                PREAMBLE: begin
                    if (bus.bit_strobe) begin
                        phy_bit_d   = pre_q[0];
                        bit_valid_d = 1'b1;
                        pre_d       = pre_q >> 1;
                        if (cnt_q == CNT_W'(LEN_PREAMBLE - 1)) begin
                            cnt_d   = '0;
                            state_d = ACCESS;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                ACCESS: begin
                    if (bus.bit_strobe) begin
                        phy_bit_d   = ubs_q[0];
                        bit_valid_d = 1'b1;
                        ubs_d       = ubs_q >> 1;
                        if (cnt_q == CNT_W'(LEN_UNIQUE_BIT_SEQUENCE - 1)) begin
                            cnt_d = '0;
                            if (num_q == 8'd0) begin
                                done_d      = 1'b1;
                                frame_end_d = 1'b1;
                            end else begin
                                state_d = PAYLOAD;
                            end
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                PAYLOAD: begin
                    if (bus.bit_strobe) begin
                        if (cnt_q == '0) begin
                            // Byte boundary: move holding byte into the shifter
                            if (!hold_full_q) begin
                                underrun_d  = 1'b1;
                                frame_end_d = 1'b1;
                            end else begin
                                phy_bit_d   = hold_q[0];
                                bit_valid_d = 1'b1;
                                shift_d     = hold_q >> 1;
                                hold_full_d = xfer;
                                loaded_d    = loaded_q + 8'd1;
                                cnt_d       = CNT_W'(1);
                            end
                        end else begin
                            phy_bit_d   = shift_q[0];
                            bit_valid_d = 1'b1;
                            shift_d     = shift_q >> 1;
                            if (cnt_q == CNT_W'(BYTE_W - 1)) begin
                                cnt_d = '0;
                                if (loaded_q == num_q) begin
                                    done_d      = 1'b1;
                                    frame_end_d = 1'b1;
                                end
                            end else begin
                                cnt_d = cnt_q + CNT_W'(1);
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d  = (state_d != IDLE);
        ready_d = busy_d & ~frame_end_d & ~hold_full_d & (fetched_d < num_d);
    end

    assign bus.phy_bit            = phy_bit_q;
    assign bus.bit_valid          = bit_valid_q;
    assign bus.busy               = busy_q;
    assign bus.done               = done_q;
    assign bus.underrun           = underrun_q;
    assign bus.payload_byte_ready = ready_q;

endmodule

// File: tb/tb_emit_unique_bit_sequence.sv
// Scoreboard bench for emit_unique_bit_sequence: expected bits queued at frame start, monitor pops per bit_valid.
module tb_emit_unique_bit_sequence;
    localparam int LP = 8;
    localparam int LU = 32;
    localparam logic [LP-1:0] PRE_A = 8'hAA;
    localparam logic [LU-1:0] UBS_A = 32'h8E89BED6;

    typedef struct packed {
        logic b;
        logic last;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    emit_unique_bit_sequence_if #(.LEN_PREAMBLE(LP), .LEN_UNIQUE_BIT_SEQUENCE(LU)) bus ();

    emit_unique_bit_sequence #(.LEN_PREAMBLE(LP), .LEN_UNIQUE_BIT_SEQUENCE(LU)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t             exp_q[$];
    exp_t             mon_e;
    logic [LP+LU-1:0] sr;
    int vectors     = 0;
    int miscompares = 0;
    int bit_cnt, done_cnt, underrun_cnt, hs_cnt, hits;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endfunction

    function automatic void fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s", name);
    endfunction

    // Monitor: compare every emitted bit against the scoreboard and count events
    always @(negedge clk) begin
        if (rst) begin
            sr = '0;
        end else begin
            if (bus.bit_valid) begin
                bit_cnt++;
                sr = {bus.phy_bit, sr[LP+LU-1:1]};
                if (sr == {UBS_A, PRE_A}) hits++;
                if (exp_q.size() == 0) begin
                    fail("unexpected_bit");
                end else begin
                    mon_e = exp_q.pop_front();
                    check("phy_bit", bus.phy_bit, mon_e.b);
                    check("done_with_bit", bus.done, mon_e.last);
                end
            end else if (bus.done) begin
                fail("done_without_bit");
            end
            if (bus.done) begin
                done_cnt++;
                check("busy_during_done", bus.busy, 1);
            end
            if (bus.underrun) underrun_cnt++;
            if (bus.payload_byte_valid && bus.payload_byte_ready) hs_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [LP-1:0] pre, input logic [LU-1:0] ubs,
                              input logic [23:0] pl, input int npb, input bit last_done);
        int   total;
        int   k;
        exp_t e;
        total = LP + LU + npb;
        k = 0;
        for (int i = 0; i < LP; i++) begin
            e.b = pre[i]; e.last = last_done && (k == total - 1); exp_q.push_back(e); k++;
        end
        for (int i = 0; i < LU; i++) begin
            e.b = ubs[i]; e.last = last_done && (k == total - 1); exp_q.push_back(e); k++;
        end
        for (int i = 0; i < npb; i++) begin
            e.b = pl[i]; e.last = last_done && (k == total - 1); exp_q.push_back(e); k++;
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_phy_bit"},   bus.phy_bit, 0);
        check({tag, "_bit_valid"}, bus.bit_valid, 0);
        check({tag, "_busy"},      bus.busy, 0);
        check({tag, "_done"},      bus.done, 0);
        check({tag, "_underrun"},  bus.underrun, 0);
        check({tag, "_ready"},     bus.payload_byte_ready, 0);
    endtask

    // One frame: strobe every 4 cycles, feed nsupply bytes, optionally reset after stop_after bits
    task automatic run_frame(input logic [LP-1:0] pre, input logic [LU-1:0] ubs, input logic [7:0] num,
                             input logic [23:0] pl, input int nsupply, input bit exp_done,
                             input bit glitch, input int stop_after);
        int npb;
        npb = exp_done ? 8 * int'(num) : 8 * nsupply;
        bit_cnt = 0; done_cnt = 0; underrun_cnt = 0; hs_cnt = 0; hits = 0;
        push_frame(pre, ubs, pl, stop_after != 0 ? 0 : npb, exp_done);

        bus.preamble = pre;
        bus.unique_bit_sequence = ubs;
        bus.num_payload_byte = num;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("busy_after_start", bus.busy, 1);

        fork
            begin
                int n   = 0;
                int cyc = 0;
                while (bus.busy && cyc < 4000 && (stop_after == 0 || n < stop_after)) begin
                    bus.bit_strobe = 1'b1;
                    if (glitch && n == 10) begin
                        bus.start = 1'b1;
                        bus.preamble = ~pre;
                        bus.unique_bit_sequence = ~ubs;
                        bus.num_payload_byte = 8'd5;
                    end
                    tick();
                    bus.bit_strobe = 1'b0;
                    bus.start = 1'b0;
                    n++;
                    repeat (3) tick();
                    cyc += 4;
                end
                if (cyc >= 4000) fail("strobe_budget_expired");
            end
            begin
                for (int i = 0; i < nsupply; i++) begin
                    int w = 0;
                    bus.payload_byte = pl[8*i +: 8];
                    bus.payload_byte_valid = 1'b1;
                    @(negedge clk);
                    while (!bus.payload_byte_ready && w < 4000) begin
                        @(negedge clk);
                        w++;
                    end
                    if (w >= 4000) fail("ready_wait_expired");
                    tick();
                end
                bus.payload_byte_valid = 1'b0;
            end
        join

        if (stop_after == 0) begin
            repeat (2) tick();
            check("bit_count", bit_cnt, LP + LU + npb);
            check("done_count", done_cnt, exp_done ? 1 : 0);
            check("underrun_count", underrun_cnt, exp_done ? 0 : 1);
            check("handshakes", hs_cnt, nsupply);
            check("busy_after_frame", bus.busy, 0);
            check("ready_after_frame", bus.payload_byte_ready, 0);
            check("queue_left", exp_q.size(), 0);
        end else begin
            check("bits_before_rst", bit_cnt, stop_after);
            check("phy_bit_before_rst", bus.phy_bit, ubs[stop_after - LP - 1]);
            rst = 1'b1;
            tick();
            check_outputs_zero("midframe_rst");
            exp_q.delete();
            rst = 1'b0;
            tick();
            bus.bit_strobe = 1'b1;
            tick();
            bus.bit_strobe = 1'b0;
            check("no_resume_bit_valid", bus.bit_valid, 0);
            check("no_resume_busy", bus.busy, 0);
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.preamble = '0;
        bus.unique_bit_sequence = '0;
        bus.num_payload_byte = '0;
        bus.bit_strobe = 1'b0;
        bus.payload_byte = '0;
        bus.payload_byte_valid = 1'b0;
        repeat (3) tick();
        check_outputs_zero("reset");
        rst = 1'b0;
        tick();

        // Strobes in IDLE must not emit anything
        for (int i = 0; i < 3; i++) begin
            bus.bit_strobe = 1'b1;
            tick();
            bus.bit_strobe = 1'b0;
            check("idle_strobe_bit_valid", bus.bit_valid, 0);
            check("idle_strobe_busy", bus.busy, 0);
            tick();
        end

        // 40-bit header-only frame with a start pulse mid-frame
        run_frame(PRE_A, UBS_A, 8'd0, 24'h0, 0, 1'b1, 1'b1, 0);
        check("searcher_hits_a", hits, 1);

        // Two payload bytes 0x01, 0x80 supplied early
        run_frame(PRE_A, UBS_A, 8'd2, 24'h00_8001, 2, 1'b1, 1'b0, 0);

        // Three bytes announced, only one supplied: underrun after 48 bits
        run_frame(PRE_A, UBS_A, 8'd3, 24'h00_005A, 1, 1'b0, 1'b0, 0);

        // Reset after 20 access-address bits
        run_frame(PRE_A, UBS_A, 8'd0, 24'h0, 0, 1'b1, 1'b0, LP + 20);

        // Full frame after reset
        run_frame(PRE_A, UBS_A, 8'd0, 24'h0, 0, 1'b1, 1'b0, 0);
        check("searcher_hits_e", hits, 1);

        // Single payload byte with a different header
        run_frame(8'h3C, 32'h1234_5678, 8'd1, 24'h00_00C3, 1, 1'b1, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout");
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/emit_unique_bit_sequence.md
EMIT_UNIQUE_BIT_SEQUENCE -- requirements
Module: emit_unique_bit_sequence

Interface
REQ-001 The block SHALL have parameters: LEN_PREAMBLE, default 8, preamble bit count; LEN_UNIQUE_BIT_SEQUENCE, default 32, access-address bit count.
REQ-002 clk  input  1  clock; all logic on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  one-cycle frame start request.
REQ-005 preamble  input  LEN_PREAMBLE  preamble pattern, sampled on accepted start.
REQ-006 unique_bit_sequence  input  LEN_UNIQUE_BIT_SEQUENCE  access address, sampled on accepted start.
REQ-007 num_payload_byte  input  8  payload byte count, 0..255, sampled on accepted start.
REQ-008 bit_strobe  input  1  advance one bit; one pulse per symbol period.
REQ-009 payload_byte  input  8  payload data.
REQ-010 payload_byte_valid  input  1  payload_byte valid.
REQ-011 payload_byte_ready  output  1  block accepts payload_byte this cycle.
REQ-012 phy_bit  output  1  serial bit, registered.
REQ-013 bit_valid  output  1  one-cycle pulse qualifying phy_bit.
REQ-014 busy  output  1  frame in progress.
REQ-015 done  output  1  one-cycle pulse, frame completed normally.
REQ-016 underrun  output  1  one-cycle pulse, frame aborted for lack of payload data.

Function
REQ-017 FSM states SHALL be IDLE, PREAMBLE, ACCESS, PAYLOAD; busy SHALL be high in every state except IDLE.
REQ-018 start in IDLE SHALL latch preamble, unique_bit_sequence and num_payload_byte and move to PREAMBLE next cycle; start while busy SHALL be ignored.
REQ-019 Each field SHALL be sent LSB first: preamble[0] first, then unique_bit_sequence[0]; each payload byte bit 0 first. This matches the receive searcher, which shifts new bits in at the MSB.
REQ-020 Each bit_strobe while busy SHALL emit exactly one bit: phy_bit valid and bit_valid=1 in the cycle after the strobe (latency 1); bit_valid SHALL otherwise be 0.
REQ-021 bit_strobe in IDLE SHALL be ignored; phy_bit SHALL hold its last value when bit_valid=0.
REQ-022 PREAMBLE SHALL emit LEN_PREAMBLE bits and then go to ACCESS.
REQ-023 ACCESS SHALL emit LEN_UNIQUE_BIT_SEQUENCE bits; after the last bit it SHALL go to PAYLOAD, or to IDLE with done if num_payload_byte=0.
REQ-024 A one-byte holding register SHALL buffer payload.
REQ-025 payload_byte_ready SHALL be busy & holding empty & (bytes fetched < num_payload_byte).
REQ-026 A transfer SHALL occur when valid & ready; prefetch SHALL be allowed from the first busy cycle.
REQ-027 In PAYLOAD, at each byte boundary (first payload strobe, then every 8th) the holding byte SHALL move to the bit shift register and the holding register SHALL become empty; a same-cycle transfer SHALL refill it.
REQ-028 If a byte boundary strobe finds the holding register empty, no bit SHALL be emitted, underrun SHALL pulse in the next cycle, and the FSM SHALL go to IDLE without done.
REQ-029 done SHALL pulse in the same cycle as bit_valid for the final bit (8*num_payload_byte-th payload bit); busy SHALL drop in the following cycle.
REQ-030 Byte and bit counters SHALL be sized for 255 bytes without wrap; total frame length SHALL be LEN_PREAMBLE+LEN_UNIQUE_BIT_SEQUENCE+8*num_payload_byte bits.
REQ-031 start in the same cycle as done/underrun return to IDLE SHALL be ignored; start SHALL be accepted only when busy=0.

Reset
REQ-032 rst high SHALL force IDLE, clear counters and holding register, and drive phy_bit, bit_valid, busy, done, underrun and payload_byte_ready to 0, including mid-frame.
REQ-033 After rst is released, the block SHALL wait for a new start; no partial frame SHALL resume.

Verification
REQ-034 preamble=0xAA, unique_bit_sequence=0x8E89BED6, num_payload_byte=0, bit_strobe every 4 cycles -> 40 bit_valid pulses, bits 0,1,0,1,...; done on 40th pulse; a searcher fed with the same pattern hits once.
REQ-035 num_payload_byte=2, bytes 0x01,0x80 supplied early -> 56 bits; payload bits 1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1; exactly 2 handshakes; done on 56th bit.
REQ-036 num_payload_byte=3, source withholds byte 2 -> 48 bit_valid pulses, underrun pulse, no done, busy=0.
REQ-037 rst asserted at bit 20 of ACCESS -> all outputs 0 next cycle; new start then sends a full 40-bit frame.
REQ-038 start pulsed while busy, and bit_strobe pulsed in IDLE -> no effect on bit count or latched fields.
